// File: rtl/pwm_capture.sv
// pwm_capture: recovers the duty value of a PWM waveform built from a 2^W-step
// ramp advancing on the shared tick strobe. High ticks are counted over one full
// ramp period and published with a one-cycle valid strobe plus line status.
// The "static" status output is named is_static because static is a reserved
// word in SystemVerilog.
module pwm_capture #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         tick,
    input  logic         pwm_in,
    output logic [W-1:0] value,
    output logic         valid,
    output logic         level,
    output logic         is_static
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pwm_s;

    // Window timer runs down from 2^W-1; terminal count 0 marks the final tick.
    logic [W-1:0]           ticks_left;
    logic [W:0]             high_cnt;
    logic                   prev;
    logic                   primed;
    logic                   edge_seen;

    logic                   qtick;
    logic                   win_end;
    logic                   edge_now;
    logic [W:0]             high_sum;
    logic [W-1:0]           duty_sat;

    assign pwm_s    = sync_q[SYNC_STAGES-1];
    assign qtick    = en & tick;
    assign win_end  = qtick & (ticks_left == '0);
    assign edge_now = primed & (pwm_s ^ prev);
    // High count including the current tick; a constant-high window reaches 2^W.
    assign high_sum = high_cnt + (W+1)'(pwm_s);
    assign duty_sat = high_sum[W] ? '1 : high_sum[W-1:0];

    // Metastability synchronizer for the asynchronous PWM line, free-running on clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    // Window measurement: tick timer, high-tick count and edge tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ticks_left <= '1;
            high_cnt   <= '0;
            prev       <= 1'b0;
            primed     <= 1'b0;
            edge_seen  <= 1'b0;
        end else if (!en) begin
            // prev is kept, but primed is cleared so it is not compared again
            // until a fresh qualified tick has reloaded it.
            ticks_left <= '1;
            high_cnt   <= '0;
            primed     <= 1'b0;
            edge_seen  <= 1'b0;
        end else if (tick) begin
            prev   <= pwm_s;
            primed <= 1'b1;
            if (win_end) begin
                ticks_left <= '1;
                high_cnt   <= '0;
                edge_seen  <= 1'b0;
            end else begin
                ticks_left <= ticks_left - 1'b1;
                high_cnt   <= high_sum;
                edge_seen  <= edge_seen | edge_now;
            end
        end
    end

    // Publish registers: load on the window-final tick, valid follows for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value     <= '0;
            valid     <= 1'b0;
            level     <= 1'b0;
            is_static <= 1'b1;
        end else begin
            valid <= win_end;
            if (win_end) begin
                value     <= duty_sat;
                level     <= pwm_s;
                is_static <= ~(edge_seen | edge_now);
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a ramp/compare PWM generator in loopback or a constant
// line drives the decoder. Directed scenarios push expected results into a
// scoreboard queue; a monitor pops and compares on every valid pulse.
module tb_pwm_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tick;
    logic       pwm_in;
    logic [7:0] value;
    logic       valid;
    logic       level;
    logic       is_static;

    // Generator state
    logic [7:0] ramp = 8'd0;
    logic [7:0] ramp_ofs = 8'd0;
    logic [7:0] ramp_eff;
    logic [7:0] duty = 8'h40;
    logic       use_gen = 1'b1;
    logic       const_lvl = 1'b0;
    int         tick_div = 1;
    int         phase = 0;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         vcount = 0;
    int         vcyc_q[$];

    typedef struct {
        logic [7:0] value;
        logic       level;
        logic       stat;
        bit         chk_level;
    } exp_t;
    exp_t sb[$];

    assign ramp_eff = ramp + ramp_ofs;
    assign pwm_in   = use_gen ? (ramp_eff < duty) : const_lvl;

    pwm_capture #(.W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .tick      (tick),
        .pwm_in    (pwm_in),
        .value     (value),
        .valid     (valid),
        .level     (level),
        .is_static (is_static)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] v, input logic lvl, input logic st, input bit cl);
        exp_t e;
        e.value = v;
        e.level = lvl;
        e.stat = st;
        e.chk_level = cl;
        sb.push_back(e);
    endtask

    task automatic wait_valids(input int n, input int budget);
        int start;
        int k;
        start = vcount;
        k = 0;
        while (vcount < start + n && k < budget) begin
            step();
            k++;
        end
        chk("valid_count", vcount - start, n);
    endtask

    // Tick strobe and ramp: the ramp advances on each tick the DUT has just registered.
    initial begin
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick) ramp = ramp + 8'd1;
            if (tick_div <= 1) begin
                tick = 1'b1;
            end else begin
                tick = (phase == 0);
                phase = (phase + 1) % tick_div;
            end
        end
    end

    // Monitor: every valid pulse pops one expectation and compares it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid === 1'b1) begin
                vcount++;
                vcyc_q.push_back(cyc);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got value %0d with empty queue, expected no valid (cycle %0d)", value, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("value", value, e.value);
                    chk("static", is_static, e.stat);
                    if (e.chk_level) chk("level", level, e.level);
                end
            end
        end
    end

    task automatic loopback(input logic [7:0] d);
        int s;
        int k;
        duty = d;
        use_gen = 1'b1;
        repeat (5) step();
        s = vcount;
        repeat (3) push_exp(d, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        k = cyc;
        wait_valids(3, 3 * 256 + 20);
        en = 1'b0;
        chk("first_latency", vcyc_q[s] - k, 256);
        chk("window_spacing", vcyc_q[s+1] - vcyc_q[s], 256);
    endtask

    task automatic constant(input logic lvl, input logic [7:0] v);
        use_gen = 1'b0;
        const_lvl = lvl;
        repeat (5) step();
        repeat (2) push_exp(v, lvl, 1'b1, 1'b1);
        en = 1'b1;
        wait_valids(2, 2 * 256 + 20);
        en = 1'b0;
    endtask

    initial begin
        int s;
        int k;
        tick_div = 1;
        repeat (3) step();
        chk("rst_value", value, 0);
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_static", is_static, 1);
        rst = 1'b0;
        repeat (5) step();

        // Loopback at full tick rate
        loopback(8'h40);
        loopback(8'h01);
        loopback(8'hFE);

        // Static lines
        constant(1'b0, 8'h00);
        constant(1'b1, 8'hFF);

        // Slow ticks, random ramp phase
        use_gen = 1'b1;
        duty = 8'h80;
        tick_div = 4;
        ramp_ofs = 8'($urandom_range(0, 255));
        repeat (20) step();
        s = vcount;
        repeat (3) push_exp(8'h80, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        wait_valids(3, 3 * 1024 + 50);
        en = 1'b0;
        chk("slow_spacing_1", vcyc_q[s+1] - vcyc_q[s], 1024);
        chk("slow_spacing_2", vcyc_q[s+2] - vcyc_q[s+1], 1024);
        tick_div = 1;
        ramp_ofs = 8'd0;

        // Enable gap mid-window
        duty = 8'h40;
        repeat (10) step();
        push_exp(8'h40, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        wait_valids(1, 300);
        repeat (100) step();
        en = 1'b0;
        s = vcount;
        repeat (10) step();
        chk("gap_no_valid", vcount, s);
        chk("gap_value_hold", value, 8'h40);
        push_exp(8'h40, 1'b0, 1'b0, 1'b0);
        s = vcount;
        en = 1'b1;
        k = cyc;
        wait_valids(1, 300);
        en = 1'b0;
        chk("reenable_latency", vcyc_q[s] - k, 256);

        // Asynchronous reset mid-window
        duty = 8'h40;
        repeat (5) step();
        en = 1'b1;
        repeat (150) step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_value", value, 0);
        chk("arst_valid", valid, 0);
        chk("arst_level", level, 0);
        chk("arst_static", is_static, 1);
        en = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        push_exp(8'h40, 1'b0, 1'b0, 1'b0);
        s = vcount;
        en = 1'b1;
        k = cyc;
        wait_valids(1, 300);
        en = 1'b0;
        chk("post_rst_latency", vcyc_q[s] - k, 256);

        // Single rising transition landing on the window-final tick
        use_gen = 1'b0;
        const_lvl = 1'b0;
        repeat (5) step();
        push_exp(8'h01, 1'b1, 1'b0, 1'b1);
        push_exp(8'hFF, 1'b1, 1'b1, 1'b1);
        en = 1'b1;
        k = cyc;
        while (cyc < k + 253) step();
        const_lvl = 1'b1;
        wait_valids(2, 600);
        en = 1'b0;

        repeat (5) step();
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion earlier", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
